// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: symbol width, the four control tokens and the
// receive-side alignment FSM states.
package tmds_pkg;

  localparam int TMDS_W = 10;

  // Control tokens as they appear in the parallel word; bit 0 is sent first.
  localparam logic [TMDS_W-1:0] TOK_CTRL0 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TOK_CTRL1 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TOK_CTRL2 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TOK_CTRL3 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  // Returns {is_token, c1, c0}; anything that is not a token is data.
  function automatic logic [2:0] tmds_token_lookup(input logic [TMDS_W-1:0] sym);
    case (sym)
      TOK_CTRL0: return 3'b100;
      TOK_CTRL1: return 3'b101;
      TOK_CTRL2: return 3'b110;
      TOK_CTRL3: return 3'b111;
      default:   return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmds_decoder_if.sv
// One TMDS lane between deserializer/sync recovery (master) and decoder (slave).
// Carries the symbol stream, decoded pixel/control output and alignment status.
interface tmds_decoder_if;

  logic                        i_valid;
  logic [tmds_pkg::TMDS_W-1:0] i_symbol;
  logic                        o_valid;
  logic                        o_de;
  logic [7:0]                  o_data;
  logic [1:0]                  o_ctrl;
  logic                        o_locked;
  logic                        o_bitslip;

  modport master (
    output i_valid, i_symbol,
    input  o_valid, o_de, o_data, o_ctrl, o_locked, o_bitslip
  );

  modport slave (
    input  i_valid, i_symbol,
    output o_valid, o_de, o_data, o_ctrl, o_locked, o_bitslip
  );

endinterface

// File: rtl/tmds_align_fsm.sv
// Word-alignment tracker: counts control-token runs, requests bit-slips, reports lock.
// locked/bitslip registered on the edge that samples the deciding symbol; no backpressure.
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int p_search_window = 2048,
  parameter int p_lock_run      = 8,
  parameter int p_slip_settle   = 16
) (
  input  logic i_clk_pixel,
  input  logic i_rst,
  input  logic sym_vld,
  input  logic sym_tok,
  output logic locked,
  output logic bitslip
);

  localparam int WIN_W = $clog2(p_search_window + 1);
  localparam int RUN_W = $clog2(p_lock_run + 1);
  localparam int SET_W = $clog2(p_slip_settle + 1);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(p_search_window - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(p_lock_run);
  localparam logic [RUN_W-1:0] RUN_QUAL = RUN_W'(p_lock_run - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(p_slip_settle - 1);

  align_state_e     state, state_nxt;
  logic [WIN_W-1:0] win_cnt, win_cnt_nxt;
  logic [RUN_W-1:0] run_cnt, run_cnt_nxt;
  logic [SET_W-1:0] settle_cnt, settle_cnt_nxt;
  logic             bitslip_nxt;
  logic             tok_vld;
  logic             dat_vld;
  logic             qualify;
  logic             expire;
  logic             settle_done;

  always_comb begin
    tok_vld     = sym_vld & sym_tok;
    dat_vld     = sym_vld & ~sym_tok;
    // A token arriving with the counter one short of (or at) saturation
    // completes a run; it also beats a simultaneous window expiry.
    qualify     = tok_vld && (run_cnt >= RUN_QUAL);
    expire      = sym_vld && !qualify && (win_cnt == WIN_LAST);
    settle_done = (settle_cnt == SET_LAST);
  end

  always_comb begin
    state_nxt   = state;
    bitslip_nxt = 1'b0;
    case (state)
      SEARCH: begin
        if (qualify) begin
          state_nxt = LOCKED;
        end else if (expire) begin
          state_nxt   = SETTLE;
          bitslip_nxt = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_done) begin
          state_nxt = SEARCH;
        end
      end
      LOCKED: begin
        if (expire) begin
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    run_cnt_nxt    = run_cnt;
    win_cnt_nxt    = win_cnt;
    settle_cnt_nxt = '0;

    if (state == SETTLE || state_nxt == SETTLE) begin
      run_cnt_nxt = '0;
    end else if (tok_vld && run_cnt != RUN_MAX) begin
      run_cnt_nxt = run_cnt + 1'b1;
    end else if (dat_vld) begin
      run_cnt_nxt = '0;
    end

    if (state == SETTLE || state_nxt != state || qualify) begin
      win_cnt_nxt = '0;
    end else if (sym_vld) begin
      win_cnt_nxt = win_cnt + 1'b1;
    end

    if (state == SETTLE && !settle_done) begin
      settle_cnt_nxt = settle_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      state      <= SEARCH;
      win_cnt    <= '0;
      run_cnt    <= '0;
      settle_cnt <= '0;
      locked     <= 1'b0;
      bitslip    <= 1'b0;
    end else begin
      state      <= state_nxt;
      win_cnt    <= win_cnt_nxt;
      run_cnt    <= run_cnt_nxt;
      settle_cnt <= settle_cnt_nxt;
      locked     <= (state_nxt == LOCKED);
      bitslip    <= bitslip_nxt;
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// One-lane TMDS receive decoder with word alignment via tmds_align_fsm.
// Two-cycle decode pipeline, one symbol per cycle, no backpressure.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int p_search_window = 2048,
  parameter int p_lock_run      = 8,
  parameter int p_slip_settle   = 16
) (
  input  logic           i_clk_pixel,
  input  logic           i_rst,
  tmds_decoder_if.slave  lane
);

  logic       in_tok;
  logic [1:0] in_ctrl;
  logic [7:0] in_d;
  logic       locked;
  logic       bitslip;

  logic       s1_vld;
  logic       s1_tok;
  logic [1:0] s1_ctrl;
  logic [7:0] s1_d;
  logic       s1_xor_sel;
  logic [7:0] s1_dec;

  logic       out_vld;
  logic       out_de;
  logic [7:0] out_dat;
  logic [1:0] out_ctrl;

  always_comb begin
    {in_tok, in_ctrl} = tmds_token_lookup(lane.i_symbol);
    in_d              = lane.i_symbol[9] ? ~lane.i_symbol[7:0] : lane.i_symbol[7:0];
  end

  tmds_align_fsm #(
    .p_search_window (p_search_window),
    .p_lock_run      (p_lock_run),
    .p_slip_settle   (p_slip_settle)
  ) u_align (
    .i_clk_pixel (i_clk_pixel),
    .i_rst       (i_rst),
    .sym_vld     (lane.i_valid),
    .sym_tok     (in_tok),
    .locked      (locked),
    .bitslip     (bitslip)
  );

  // Only symbols accepted while already locked enter the pipeline.
  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      s1_vld     <= 1'b0;
      s1_tok     <= 1'b0;
      s1_ctrl    <= '0;
      s1_d       <= '0;
      s1_xor_sel <= 1'b0;
    end else begin
      s1_vld <= lane.i_valid & locked;
      if (lane.i_valid) begin
        s1_tok     <= in_tok;
        s1_ctrl    <= in_ctrl;
        s1_d       <= in_d;
        s1_xor_sel <= lane.i_symbol[8];
      end
    end
  end

  always_comb begin
    s1_dec    = '0;
    s1_dec[0] = s1_d[0];
    for (int i = 1; i < 8; i++) begin
      s1_dec[i] = s1_xor_sel ? (s1_d[i] ^ s1_d[i-1]) : ~(s1_d[i] ^ s1_d[i-1]);
    end
  end

  // o_ctrl only moves on tokens so downstream sync recovery sees a stable value.
  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      out_vld  <= 1'b0;
      out_de   <= 1'b0;
      out_dat  <= '0;
      out_ctrl <= '0;
    end else begin
      out_vld <= s1_vld;
      if (s1_vld) begin
        out_de  <= ~s1_tok;
        out_dat <= s1_tok ? 8'h00 : s1_dec;
        if (s1_tok) begin
          out_ctrl <= s1_ctrl;
        end
      end
    end
  end

  assign lane.o_valid   = out_vld;
  assign lane.o_de      = out_de;
  assign lane.o_data    = out_dat;
  assign lane.o_ctrl    = out_ctrl;
  assign lane.o_locked  = locked;
  assign lane.o_bitslip = bitslip;

endmodule
